hex_display_scanner: RTL and testbench

Time-multiplexed driver for a four-digit common-anode seven-segment display. It holds a 16-bit value and scans one hex digit per refresh slot. For each slot it presents that digit's nibble on x3..x0 to the downstream seven-segment decoder and drives the matching active-low digit enable. New values are double-buffered and take effect only at frame boundaries, so a frame never shows a mix of old and new digits.

---
 rtl/hex_display_scanner.sv | 88 ++++++++
 tb/tb_hex_display_scanner.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/hex_display_scanner.sv
// Four-digit time-multiplexed hex display scanner.
// One nibble is shown per refresh slot. A new value is held in a shadow
// register and only reaches the display register at a frame wrap, so a
// frame is never a mix of two values.
module hex_display_scanner #(
  parameter int REFRESH_DIV = 50000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [15:0] value_in,
  input  logic        blank_lz,
  output logic        x3,
  output logic        x2,
  output logic        x1,
  output logic        x0,
  output logic [3:0]  an,
  output logic        frame_tick
);

  localparam int PW = $clog2(REFRESH_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);

  logic [PW-1:0] prescaler_reg, prescaler_next;
  logic [1:0]    idx_reg, idx_next;
  logic [15:0]   disp_reg, disp_next;
  logic [15:0]   shad_reg, shad_next;
  logic          pending_reg, pending_next;
  logic [3:0]    nib_reg, nib_next;
  logic [3:0]    an_reg, an_next;
  logic          tick_reg, tick_next;
  logic          slot_end, wrap;
  logic [3:0]    blank_mask;

  // Next-state for the scan position, buffering and the registered outputs.
  // Outputs are derived from next-state so they line up with idx/disp.
  always_comb begin
    slot_end       = (prescaler_reg == PRESC_LAST);
    wrap           = slot_end && (idx_reg == 2'd3);
    prescaler_next = slot_end ? '0 : prescaler_reg + PW'(1);
    idx_next       = slot_end ? idx_reg + 2'd1 : idx_reg;

    // The wrap transfers the pre-edge shadow; a load on that same cycle
    // only refills the shadow and re-arms pending for the next wrap.
    disp_next    = (wrap && pending_reg) ? shad_reg : disp_reg;
    shad_next    = load ? value_in : shad_reg;
    pending_next = load ? 1'b1 : (wrap ? 1'b0 : pending_reg);

    // Digit k>0 is dark when it and every more significant nibble is zero.
    blank_mask = 4'b0000;
    for (int k = 1; k < 4; k++) begin
      blank_mask[k] = blank_lz && ((disp_next >> (4 * k)) == 16'd0);
    end

    nib_next  = disp_next[4*idx_next +: 4];
    an_next   = blank_mask[idx_next] ? 4'b1111 : ~(4'b0001 << idx_next);
    // Raised on the cycle whose state will produce the wrap.
    tick_next = (prescaler_next == PRESC_LAST) && (idx_next == 2'd3);
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prescaler_reg <= '0;
      idx_reg       <= 2'd0;
      disp_reg      <= 16'd0;
      shad_reg      <= 16'd0;
      pending_reg   <= 1'b0;
      nib_reg       <= 4'd0;
      an_reg        <= 4'b1111;
      tick_reg      <= 1'b0;
    end else begin
      prescaler_reg <= prescaler_next;
      idx_reg       <= idx_next;
      disp_reg      <= disp_next;
      shad_reg      <= shad_next;
      pending_reg   <= pending_next;
      nib_reg       <= nib_next;
      an_reg        <= an_next;
      tick_reg      <= tick_next;
    end
  end

  assign {x3, x2, x1, x0} = nib_reg;
  assign an               = an_reg;
  assign frame_tick       = tick_reg;

endmodule

// File: tb/tb_hex_display_scanner.sv
// Scoreboard bench for hex_display_scanner with REFRESH_DIV = 4.
// Stimulus pushes the expected per-slot display into a queue; the monitor
// samples mid-slot on the falling edge and compares against the queue head.
module tb_hex_display_scanner;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load = 1'b0;
  logic [15:0] value_in = 16'd0;
  logic        blank_lz = 1'b0;
  logic        x3, x2, x1, x0;
  logic [3:0]  an;
  logic        frame_tick;

  hex_display_scanner #(.REFRESH_DIV(4)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .value_in(value_in),
    .blank_lz(blank_lz), .x3(x3), .x2(x2), .x1(x1), .x0(x0),
    .an(an), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         epoch;
    int         frame;
    int         slot;
    logic [3:0] an;
    logic [3:0] nib;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   epoch = 0;
  int   ecount = 0;

  // Rising edges since the last reset release (edge 1 is the first one).
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) ecount <= 0;
    else        ecount <= ecount + 1;
  end

  task automatic check(input string name, input logic [3:0] got, input logic [3:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Push one frame: nibbles come from val, anodes from ans = {an3,an2,an1,an0}.
  task automatic push_frame(input int f, input logic [15:0] val, input logic [15:0] ans);
    for (int s = 0; s < 4; s++) begin
      exp_t e;
      e.epoch = epoch;
      e.frame = f;
      e.slot  = s;
      e.nib   = val[4*s +: 4];
      e.an    = ans[4*s +: 4];
      q.push_back(e);
    end
  endtask

  task automatic wait_after(input int n);
    int guard = 0;
    while (ecount < n && guard < 2000) begin
      @(posedge clk);
      #1;
      guard++;
    end
    n_cmp++;
    if (ecount != n) begin
      n_err++;
      $display("FAIL sync: edge count %0d expected %0d", ecount, n);
    end
  endtask

  task automatic pulse_load(input logic [15:0] v);
    load = 1'b1;
    value_in = v;
    @(posedge clk);
    #1;
    load = 1'b0;
  endtask

  // Monitor: frame_tick every cycle, slot contents mid-slot.
  always @(negedge clk) begin
    if (rst_n && ecount > 0) begin
      int f, s, key;
      f   = ecount / 16;
      s   = (ecount % 16) / 4;
      key = f * 4 + s;
      n_cmp++;
      if (frame_tick !== ((ecount % 16) == 15)) begin
        n_err++;
        $display("FAIL frame_tick: got %b expected %b at edge %0d",
                 frame_tick, ((ecount % 16) == 15), ecount);
      end
      if ((ecount % 4) == 2) begin
        while (q.size() > 0 && (q[0].epoch < epoch ||
               (q[0].epoch == epoch && q[0].frame * 4 + q[0].slot < key))) begin
          n_cmp++;
          n_err++;
          $display("FAIL missed: epoch %0d frame %0d slot %0d never observed",
                   q[0].epoch, q[0].frame, q[0].slot);
          void'(q.pop_front());
        end
        if (q.size() > 0 && q[0].epoch == epoch && q[0].frame == f && q[0].slot == s) begin
          check($sformatf("an f%0d s%0d", f, s), an, q[0].an);
          check($sformatf("nibble f%0d s%0d", f, s), {x3, x2, x1, x0}, q[0].nib);
          $display("slot ep%0d f%0d s%0d: an=%b nib=%h", epoch, f, s, an, {x3, x2, x1, x0});
          void'(q.pop_front());
        end
      end
    end
  end

  // Stimulus.
  initial begin
    // Reset held.
    @(posedge clk);
    #1;
    check("reset an", an, 4'b1111);
    check("reset nibble", {x3, x2, x1, x0}, 4'h0);
    check("reset tick", {3'b000, frame_tick}, 4'h0);
    push_frame(0, 16'h0000, 16'h7BDE);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("first edge an", an, 4'b1110);
    check("first edge nibble", {x3, x2, x1, x0}, 4'h0);

    // Scan order: value arrives at the first wrap.
    wait_after(2);
    push_frame(1, 16'h1A3F, 16'h7BDE);
    pulse_load(16'h1A3F);

    // Leading-zero blanking on 0070.
    wait_after(19);
    blank_lz = 1'b1;
    push_frame(2, 16'h0070, 16'hFFDE);
    pulse_load(16'h0070);

    // Zero value: only digit 0 lit.
    wait_after(35);
    push_frame(3, 16'h0000, 16'hFFFE);
    pulse_load(16'h0000);

    // Blanking off: all four digits lit.
    wait_after(64);
    push_frame(4, 16'h0000, 16'h7BDE);
    blank_lz = 1'b0;

    // Old value for the deferred-update frame.
    wait_after(69);
    push_frame(5, 16'hABCD, 16'h7BDE);
    pulse_load(16'hABCD);

    // Two loads mid-frame: only the last one shows, one frame later.
    wait_after(85);
    pulse_load(16'h1234);
    wait_after(87);
    push_frame(6, 16'h5678, 16'h7BDE);
    pulse_load(16'h5678);

    // Load on the frame_tick cycle lands one frame late.
    wait_after(111);
    check("tick before collision", {3'b000, frame_tick}, 4'h1);
    push_frame(7, 16'h5678, 16'h7BDE);
    push_frame(8, 16'hBEEF, 16'h7BDE);
    pulse_load(16'hBEEF);

    // Mid-operation reset with a load pending.
    wait_after(145);
    q.push_back('{epoch, 9, 0, 4'b1110, 4'hF});
    q.push_back('{epoch, 9, 1, 4'b1101, 4'hE});
    pulse_load(16'h9999);
    wait_after(153);
    #2;
    rst_n = 1'b0;
    #1;
    check("async reset an", an, 4'b1111);
    check("async reset nibble", {x3, x2, x1, x0}, 4'h0);
    check("async reset tick", {3'b000, frame_tick}, 4'h0);
    epoch = 1;
    push_frame(0, 16'h0000, 16'h7BDE);
    push_frame(1, 16'h0000, 16'h7BDE);
    @(posedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("restart an", an, 4'b1110);
    check("restart nibble", {x3, x2, x1, x0}, 4'h0);

    begin
      int guard = 0;
      while (q.size() > 0 && guard < 200) begin
        @(posedge clk);
        guard++;
      end
    end
    n_cmp++;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expected slots left, required 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Watchdog against a stalled run.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "timeout");
  end

endmodule
